// File: rtl/mem_byte_seq_pkg.sv
// Shared constants for the byte-serial memory sequencer: bus command codes,
// access size codes, FSM state encoding and the byte-count helper.
package mem_byte_seq_pkg;

    localparam logic [1:0] RwNone  = 2'b00;
    localparam logic [1:0] RwLoad  = 2'b01;
    localparam logic [1:0] RwStore = 2'b10;

    localparam logic [1:0] SizeB = 2'b00;
    localparam logic [1:0] SizeH = 2'b01;
    localparam logic [1:0] SizeW = 2'b10;

    localparam logic        Enable   = 1'b1;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [7:0]  ZeroByte = 8'h00;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_t;

    // Size code 11 is treated as a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SizeB:   byte_count = 3'd1;
            SizeH:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq_load_ext.sv
// Sign/zero extender for assembled little-endian load bytes.
module mem_byte_seq_load_ext
    import mem_byte_seq_pkg::*;
(
    input  logic [31:0] bytes,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    always_comb begin
        result = bytes;
        case (size)
            SizeB:   result = {{24{is_signed & bytes[7]}}, bytes[7:0]};
            SizeH:   result = {{16{is_signed & bytes[15]}}, bytes[15:0]};
            default: result = bytes;
        endcase
    end

endmodule

// File: rtl/mem_byte_seq.sv
// Turns one 8/16/32-bit load or store into a little-endian run of single-byte
// bus cycles; loads collect the byte returned one cycle after each address.
module mem_byte_seq
    import mem_byte_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rw_to_ctrl,
    output logic [ADDR_W-1:0] addr_to_ctrl,
    output logic [7:0]        data_to_ctrl,
    input  logic [7:0]        data_from_ctrl
);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] bytes_q, cap_bytes, ext_out, rdata_d;
    logic [1:0]        rw_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;
    logic [2:0]        n;
    logic [1:0]        cap_idx;
    logic              accept;

    assign accept  = req_valid && (req_rw == RwLoad || req_rw == RwStore);
    assign n       = byte_count(size_q);
    assign cap_idx = cnt_q[1:0] - 2'd1;
    assign done    = (state_q == StDone);
    assign busy    = (state_q == StRun) || (state_q == StIdle && accept);

    // The byte on data_from_ctrl belongs to the address driven one cycle earlier.
    always_comb begin
        cap_bytes = bytes_q;
        if (state_q == StRun && op_q == RwLoad && cnt_q != 3'd0)
            cap_bytes[{cap_idx, 3'b000} +: 8] = data_from_ctrl;
    end

    mem_byte_seq_load_ext u_load_ext (
        .bytes     (cap_bytes),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (ext_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_to_ctrl;
        addr_d  = addr_to_ctrl;
        data_d  = data_to_ctrl;
        rdata_d = rdata;
        case (state_q)
            StIdle: begin
                rw_d = RwNone;
                if (accept) begin
                    state_d = StRun;
                    cnt_d   = 3'd0;
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    data_d  = (req_rw == RwStore) ? req_wdata[7:0] : ZeroByte;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 3'd1;
                if (op_q == RwStore) begin
                    if (cnt_q == n - 3'd1) begin
                        state_d = StDone;
                        rw_d    = RwNone;
                        data_d  = ZeroByte;
                    end else begin
                        addr_d = base_q + ADDR_W'(cnt_d);
                        data_d = wdata_q[{cnt_d[1:0], 3'b000} +: 8];
                    end
                end else begin
                    // Loads need one extra cycle to catch the last returned byte.
                    if (cnt_q == n) begin
                        state_d = StDone;
                        rdata_d = ext_out;
                    end else if (cnt_q == n - 3'd1) begin
                        rw_d = RwNone;
                    end else begin
                        addr_d = base_q + ADDR_W'(cnt_d);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                rw_d    = RwNone;
            end
            default: begin
                state_d = StIdle;
                rw_d    = RwNone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == Enable) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            rw_to_ctrl   <= RwNone;
            addr_to_ctrl <= '0;
            data_to_ctrl <= ZeroByte;
            rdata        <= ZeroWord;
            bytes_q      <= ZeroWord;
            op_q         <= RwNone;
            base_q       <= '0;
            size_q       <= SizeB;
            signed_q     <= 1'b0;
            wdata_q      <= ZeroWord;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rw_to_ctrl   <= rw_d;
            addr_to_ctrl <= addr_d;
            data_to_ctrl <= data_d;
            rdata        <= rdata_d;
            bytes_q      <= cap_bytes;
            if (state_q == StIdle && accept) begin
                op_q     <= req_rw;
                base_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_seq.sv
// Directed bench for mem_byte_seq with a 16-byte RAM model answering loads.
module tb_mem_byte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_rw;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  rw_to_ctrl;
    logic [31:0] addr_to_ctrl;
    logic [7:0]  data_to_ctrl;
    logic [7:0]  data_from_ctrl = 8'h00;

    logic [7:0]  ram [16];
    int          total = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    mem_byte_seq #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_wdata      (req_wdata),
        .busy           (busy),
        .done           (done),
        .rdata          (rdata),
        .rw_to_ctrl     (rw_to_ctrl),
        .addr_to_ctrl   (addr_to_ctrl),
        .data_to_ctrl   (data_to_ctrl),
        .data_from_ctrl (data_from_ctrl)
    );

    // Memory controller model: read byte appears one cycle after its address.
    always @(posedge clk)
        data_from_ctrl <= (rw_to_ctrl == 2'b01) ? ram[addr_to_ctrl[3:0]] : 8'h00;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic [1:0] rw, input logic [31:0] addr,
                             input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_rw     = rw;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        #1;
    endtask

    task automatic drop_req;
        req_valid = 1'b0;
        req_rw    = 2'b00;
        #1;
    endtask

    // Called in the cycle the request is first presented; returns in the done cycle.
    task automatic check_store(input string tag, input logic [31:0] base, input int n,
                               input logic [31:0] wdata);
        logic [31:0] a;
        logic [31:0] d;
        chk({tag, "_busy_req"}, 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            tick;
            a = base + 32'(k);
            d = (wdata >> (8 * k)) & 32'hFF;
            chk({tag, "_rw"}, 32'(rw_to_ctrl), 32'd2);
            chk({tag, "_addr"}, addr_to_ctrl, a);
            chk({tag, "_data"}, 32'(data_to_ctrl), d);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
        end
        tick;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_rw_done"}, 32'(rw_to_ctrl), 32'd0);
    endtask

    task automatic check_load(input string tag, input logic [31:0] base, input int n,
                              input logic [31:0] exp_rdata);
        chk({tag, "_busy_req"}, 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            tick;
            chk({tag, "_rw"}, 32'(rw_to_ctrl), 32'd1);
            chk({tag, "_addr"}, addr_to_ctrl, base + 32'(k));
            chk({tag, "_nodone"}, 32'(done), 32'd0);
        end
        tick;
        chk({tag, "_rw_last"}, 32'(rw_to_ctrl), 32'd0);
        chk({tag, "_busy_last"}, 32'(busy), 32'd1);
        chk({tag, "_nodone_last"}, 32'(done), 32'd0);
        tick;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'(i);
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
        ram[4] = 8'h80; ram[5] = 8'h34; ram[6] = 8'h92;

        rst = 1'b1;
        req_valid = 1'b0; req_rw = 2'b00; req_addr = 32'h0;
        req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'h0;
        tick; tick; tick;
        chk("rst_rw", 32'(rw_to_ctrl), 32'd0);
        chk("rst_addr", addr_to_ctrl, 32'h0);
        chk("rst_data", 32'(data_to_ctrl), 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        tick;

        drive_req(2'b10, 32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF);
        check_store("sw", 32'h0000_0100, 4, 32'hDEAD_BEEF);
        chk("sw_rdata_held", rdata, 32'h0);
        drop_req; tick;

        drive_req(2'b01, 32'h0000_0200, 2'b10, 1'b0, 32'h0);
        check_load("lw", 32'h0000_0200, 4, 32'h4433_2211);
        drop_req; tick;

        drive_req(2'b01, 32'h0000_0204, 2'b00, 1'b1, 32'h0);
        check_load("lb", 32'h0000_0204, 1, 32'hFFFF_FF80);
        drop_req; tick;

        drive_req(2'b01, 32'h0000_0204, 2'b00, 1'b0, 32'h0);
        check_load("lbu", 32'h0000_0204, 1, 32'h0000_0080);
        drop_req; tick;

        drive_req(2'b01, 32'h0000_0205, 2'b01, 1'b1, 32'h0);
        check_load("lh", 32'h0000_0205, 2, 32'hFFFF_9234);
        drop_req; tick;

        drive_req(2'b01, 32'h0000_0205, 2'b01, 1'b0, 32'h0);
        check_load("lhu", 32'h0000_0205, 2, 32'h0000_9234);
        drop_req; tick;

        drive_req(2'b10, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0000_ABCD);
        check_store("sh_wrap", 32'hFFFF_FFFF, 2, 32'h0000_ABCD);
        chk("sh_rdata_held", rdata, 32'h0000_9234);
        drop_req; tick;

        // Back-to-back: the new request is presented during the first DONE cycle.
        drive_req(2'b10, 32'h0000_0300, 2'b00, 1'b0, 32'h0000_005A);
        check_store("sb1", 32'h0000_0300, 1, 32'h0000_005A);
        drive_req(2'b10, 32'h0000_0301, 2'b00, 1'b0, 32'h0000_00C3);
        chk("b2b_busy_in_done", 32'(busy), 32'd0);
        tick;
        chk("b2b_idle_rw", 32'(rw_to_ctrl), 32'd0);
        chk("b2b_idle_done", 32'(done), 32'd0);
        check_store("sb2", 32'h0000_0301, 1, 32'h0000_00C3);
        drop_req; tick;

        drive_req(2'b00, 32'h0000_0400, 2'b10, 1'b0, 32'h1234_5678);
        chk("norw00_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("norw00_rw", 32'(rw_to_ctrl), 32'd0);
            chk("norw00_done", 32'(done), 32'd0);
            chk("norw00_busy_hold", 32'(busy), 32'd0);
        end
        drive_req(2'b11, 32'h0000_0400, 2'b10, 1'b0, 32'h1234_5678);
        chk("norw11_busy", 32'(busy), 32'd0);
        tick;
        chk("norw11_rw", 32'(rw_to_ctrl), 32'd0);
        drop_req; tick;

        drive_req(2'b01, 32'h0000_0208, 2'b10, 1'b0, 32'h0);
        tick;
        chk("rstmid_addr0", addr_to_ctrl, 32'h0000_0208);
        tick;
        chk("rstmid_addr1", addr_to_ctrl, 32'h0000_0209);
        rst = 1'b1;
        drop_req;
        tick;
        chk("rstmid_rw", 32'(rw_to_ctrl), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_rdata", rdata, 32'h0);
        chk("rstmid_addr", addr_to_ctrl, 32'h0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("postrst_rw", 32'(rw_to_ctrl), 32'd0);
            chk("postrst_done", 32'(done), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
